mmio_bridge: RTL and testbench

//  Sits directly downstream of the instruction controller's IO decode (IORead_singal/IOWrite_singal,

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_if.sv | 21 ++
 rtl/input_debouncer.sv | 48 ++++
 rtl/mmio_bridge.sv | 93 +++++++++
 tb/tb_mmio_bridge.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the board IO window: high-address match used by the controller
// decode, and the word offsets of the IO registers inside the window.
package mmio_pkg;

    localparam int unsigned ADDR_LOW_W = 10;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned IO_HIGH_W  = 22;

    localparam logic [IO_HIGH_W-1:0]  IO_HIGH_ADDR = 22'h3FFFFF;

    localparam logic [ADDR_LOW_W-1:0] OFF_SW  = 10'h000;
    localparam logic [ADDR_LOW_W-1:0] OFF_BTN = 10'h004;
    localparam logic [ADDR_LOW_W-1:0] OFF_LED = 10'h060;
    localparam logic [ADDR_LOW_W-1:0] OFF_SEG = 10'h080;

    // True when a full byte address falls in the 0xFFFFFC00-0xFFFFFFFF IO window.
    function automatic logic is_io_addr(input logic [DATA_W-1:0] addr);
        return addr[DATA_W-1:ADDR_LOW_W] == IO_HIGH_ADDR;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Core-side IO access bus: controller load/store strobes, offset, data and write-back word.
interface mmio_if
    import mmio_pkg::*;
;
    logic                  io_read;
    logic                  io_write;
    logic [ADDR_LOW_W-1:0] addr_low;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic [DATA_W-1:0]     rf_wdata;

    modport master (
        output io_read, io_write, addr_low, wdata, mem_rdata,
        input  rf_wdata
    );

    modport slave (
        input  io_read, io_write, addr_low, wdata, mem_rdata,
        output rf_wdata
    );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a hold-time qualifier: a new input vector is accepted
// only after it has differed from the accepted value for CYCLES consecutive edges.
module input_debouncer #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_nxt_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Count only while the synced input disagrees; the top count value accepts it.
    always_comb begin
        stable_nxt_c = stable;
        cnt_nxt      = '0;
        if (sync2 != stable) begin
            if (cnt == CNT_W'(CYCLES - 1)) begin
                stable_nxt_c = sync2;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            cnt    <= cnt_nxt;
            stable <= stable_nxt_c;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Board IO register block behind the controller's IO decode: LED/7-seg registers,
// debounced switches, sticky button event, and the register-file write-back select.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned LED_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_if.slave                bus,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic                 btn_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [DATA_W-1:0]    seg_data
);

    localparam int unsigned WORD_W = ADDR_LOW_W - 2;

    localparam logic [WORD_W-1:0] WORD_SW  = OFF_SW[ADDR_LOW_W-1:2];
    localparam logic [WORD_W-1:0] WORD_BTN = OFF_BTN[ADDR_LOW_W-1:2];
    localparam logic [WORD_W-1:0] WORD_LED = OFF_LED[ADDR_LOW_W-1:2];
    localparam logic [WORD_W-1:0] WORD_SEG = OFF_SEG[ADDR_LOW_W-1:2];

    logic [SW_WIDTH-1:0] sw_db;
    logic [SW_WIDTH-1:0] unused_sw_nxt;
    logic [0:0]          btn_db;
    logic [0:0]          btn_nxt;
    logic                btn_rise_c;
    logic                btn_flag;
    logic [WORD_W-1:0]   word;
    logic                unused_addr_lsb;
    logic [DATA_W-1:0]   io_rdata;

    input_debouncer #(.WIDTH(SW_WIDTH), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk          (clk),
        .rst          (rst),
        .raw          (sw_in),
        .stable       (sw_db),
        .stable_nxt_c (unused_sw_nxt)
    );

    input_debouncer #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk          (clk),
        .rst          (rst),
        .raw          (btn_in),
        .stable       (btn_db),
        .stable_nxt_c (btn_nxt)
    );

    // Byte lanes are not decoded; only the word offset selects a register.
    assign word            = bus.addr_low[ADDR_LOW_W-1:2];
    assign unused_addr_lsb = ^bus.addr_low[1:0];

    // Rise is taken from the debouncer's next value so the flag sets on the same edge.
    assign btn_rise_c = btn_nxt[0] & ~btn_db[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out  <= '0;
            seg_data <= '0;
            btn_flag <= 1'b0;
        end else begin
            if (bus.io_write && word == WORD_LED) begin
                led_out <= bus.wdata[LED_WIDTH-1:0];
            end
            if (bus.io_write && word == WORD_SEG) begin
                seg_data <= bus.wdata;
            end
            // A new event beats a concurrent clear-on-read so no press is lost.
            if (btn_rise_c) begin
                btn_flag <= 1'b1;
            end else if (bus.io_read && word == WORD_BTN) begin
                btn_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (word)
            WORD_SW:  io_rdata = DATA_W'(sw_db);
            WORD_BTN: io_rdata = DATA_W'(btn_flag);
            WORD_LED: io_rdata = DATA_W'(led_out);
            WORD_SEG: io_rdata = seg_data;
            default:  io_rdata = '0;
        endcase
    end

    assign bus.rf_wdata = bus.io_read ? io_rdata : bus.mem_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a short debounce window.
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_in;
    logic        btn_in;
    logic [15:0] led_out;
    logic [31:0] seg_data;

    int n_checks = 0;
    int n_errors = 0;

    mmio_if bus ();

    mmio_bridge #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(16), .LED_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sw_in    (sw_in),
        .btn_in   (btn_in),
        .led_out  (led_out),
        .seg_data (seg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; drive and sample 1 ns / 2 ns after it, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] wd);
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.addr_low = a;
        bus.wdata    = wd;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        sw_in         = 16'hFFFF;
        btn_in        = 1'b0;
        bus.mem_rdata = 32'h0;
        drive(1'b1, 1'b0, OFF_SW, 32'h0);

        // Reset held with switches high
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", 32'(led_out), 32'h0);
            check("rst_seg", seg_data, 32'h0);
            check("rst_sw_read", bus.rf_wdata, 32'h0);
        end
        rst   = 1'b0;
        sw_in = 16'h0000;
        step();
        drive(1'b1, 1'b0, OFF_BTN, 32'h0);
        check("rst_btn_read", bus.rf_wdata, 32'h0);

        // LED write, upper bits dropped; visible after the edge
        drive(1'b0, 1'b1, OFF_LED, 32'hABCD_1234);
        check("led_before_edge", 32'(led_out), 32'h0);
        step();
        drive(1'b1, 1'b0, OFF_LED, 32'h0);
        check("led_out", 32'(led_out), 32'h0000_1234);
        check("led_read", bus.rf_wdata, 32'h0000_1234);
        drive(1'b1, 1'b0, 10'h062, 32'h0);
        check("led_read_lsb_ignored", bus.rf_wdata, 32'h0000_1234);

        // SEG write and read-back
        drive(1'b0, 1'b1, OFF_SEG, 32'h8765_4321);
        step();
        drive(1'b1, 1'b0, OFF_SEG, 32'h0);
        check("seg_out", seg_data, 32'h8765_4321);
        check("seg_read", bus.rf_wdata, 32'h8765_4321);

        // Writes to read-only / unmapped offsets change nothing
        drive(1'b0, 1'b1, OFF_SW, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b1, 10'h3F0, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b0, 10'h0, 32'h0);
        check("ro_write_led", 32'(led_out), 32'h0000_1234);
        check("ro_write_seg", seg_data, 32'h8765_4321);

        // Mux: memory path vs unmapped IO read
        bus.mem_rdata = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, OFF_SW, 32'h0);
        check("mem_path", bus.rf_wdata, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 10'h3F0, 32'h0);
        check("unmapped_read", bus.rf_wdata, 32'h0);
        drive(1'b1, 1'b0, OFF_SW, 32'h0);
        check("sw_read_idle", bus.rf_wdata, 32'h0);

        // Switch change accepted on edge 6
        sw_in = 16'h00A5;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("sw_hold_e%0d", i), bus.rf_wdata, 32'h0);
        end
        step();
        check("sw_accept_e6", bus.rf_wdata, 32'h0000_00A5);

        // 3-cycle glitch must be rejected
        sw_in = 16'h005A;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) sw_in = 16'h00A5;
            check($sformatf("sw_glitch_c%0d", i), bus.rf_wdata, 32'h0000_00A5);
        end

        // Button held 8 cycles: sticky flag, clear-on-read
        drive(1'b0, 1'b0, OFF_BTN, 32'h0);
        btn_in = 1'b1;
        repeat (8) step();
        drive(1'b1, 1'b0, OFF_BTN, 32'h0);
        check("btn_read_set", bus.rf_wdata, 32'h1);
        step();
        check("btn_read_cleared", bus.rf_wdata, 32'h0);
        drive(1'b0, 1'b0, OFF_BTN, 32'h0);
        btn_in = 1'b0;
        repeat (10) step();
        drive(1'b1, 1'b0, OFF_BTN, 32'h0);
        check("btn_release_no_flag", bus.rf_wdata, 32'h0);
        drive(1'b0, 1'b0, OFF_BTN, 32'h0);

        // Debounced rise on the same edge as a BTN read: set wins
        btn_in = 1'b1;
        repeat (5) step();
        drive(1'b1, 1'b0, OFF_BTN, 32'h0);
        check("btn_race_read_old", bus.rf_wdata, 32'h0);
        step();
        check("btn_race_set_wins", bus.rf_wdata, 32'h1);
        step();
        check("btn_race_cleared", bus.rf_wdata, 32'h0);

        // Reset mid-debounce re-qualifies from scratch
        drive(1'b1, 1'b0, OFF_SW, 32'h0);
        sw_in = 16'h1111;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_sw", bus.rf_wdata, 32'h0);
        check("rst_mid_led", 32'(led_out), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("sw_requal_e%0d", i), bus.rf_wdata, 32'h0);
        end
        step();
        check("sw_requal_accept", bus.rf_wdata, 32'h0000_1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
